// File: rtl/vec_extend_seq_pkg.sv
// rtl/vec_extend_seq_pkg.sv - fill-mode encodings and sweep order for the vector extension stage
package vec_extend_seq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ZERO = 2'd0;
    localparam mode_t MODE_SIGN = 2'd1;
    localparam mode_t MODE_ONES = 2'd2;
    localparam mode_t MODE_HIZ  = 2'd3;

    // Sweep order: ZERO -> SIGN -> ONES -> HIZ -> ZERO.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_ZERO: n = MODE_SIGN;
            MODE_SIGN: n = MODE_ONES;
            MODE_ONES: n = MODE_HIZ;
            default:   n = MODE_ZERO;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vext_sweep_seq.sv
// rtl/vext_sweep_seq.sv - free-running fill-mode sequencer, one mode per STEP_CYCLES cycles
module vext_sweep_seq
    import vec_extend_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sweep_en,
    output logic [1:0] sweep_mode
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] timer;

    // Disabling the sweep parks it at ZERO so every re-enable starts a full period.
    always_ff @(posedge clk) begin
        if (rst || !sweep_en) begin
            timer      <= '0;
            sweep_mode <= MODE_ZERO;
        end else if (timer == LAST) begin
            timer      <= '0;
            sweep_mode <= next_mode(sweep_mode);
        end else begin
            timer      <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/vec_extend_seq.sv
// rtl/vec_extend_seq.sv - widens IN_W-bit words to OUT_W bits with a selectable fill, one-entry output register
module vec_extend_seq
    import vec_extend_seq_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 32,
    parameter int STEP_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             sweep_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_oe,
    output logic [1:0]       out_mode,
    output logic [1:0]       sweep_mode
);

    logic [OUT_W-1:0] ext_word;
    logic [OUT_W-1:0] data_q;
    logic [1:0]       mode_q;
    logic [1:0]       eff_mode;
    logic             xfer;

    vext_sweep_seq #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .sweep_en   (sweep_en),
        .sweep_mode (sweep_mode)
    );

    assign eff_mode = sweep_en ? sweep_mode : in_mode;
    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // HIZ stores a zero-filled word; only the output drivers differ.
    if (OUT_W < IN_W) begin : g_bad_width
        $error("vec_extend_seq: OUT_W must be >= IN_W");
    end

    if (OUT_W > IN_W) begin : g_wide
        logic fill;
        assign fill     = (eff_mode == MODE_SIGN) ? in_data[IN_W-1] : (eff_mode == MODE_ONES);
        assign ext_word = {{(OUT_W-IN_W){fill}}, in_data};
    end else begin : g_same
        assign ext_word = in_data[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_q    <= '0;
            mode_q    <= MODE_ZERO;
        end else if (xfer) begin
            out_valid <= 1'b1;
            data_q    <= ext_word;
            mode_q    <= eff_mode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_oe   = (mode_q != MODE_HIZ);
    assign out_mode = mode_q;
    assign out_data = out_oe ? data_q : {OUT_W{1'bz}};

endmodule

// File: tb/tb_vec_extend_seq.sv
// tb/tb_vec_extend_seq.sv - directed self-checking bench for vec_extend_seq (IN_W=8, OUT_W=32, STEP_CYCLES=5)
module tb_vec_extend_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_mode;
    logic        sweep_en;
    logic        out_valid;
    logic        out_ready;
    wire  [31:0] out_data;
    logic        out_oe;
    logic [1:0]  out_mode;
    logic [1:0]  sweep_mode;

    int n_cmp = 0;
    int n_bad = 0;

    vec_extend_seq #(
        .IN_W        (8),
        .OUT_W       (32),
        .STEP_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .sweep_en   (sweep_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_oe     (out_oe),
        .out_mode   (out_mode),
        .sweep_mode (sweep_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] forbidden);
        n_cmp++;
        assert (obs !== forbidden) else begin
            n_bad++;
            $error("FAIL %s: observed %h must differ from %h", tag, obs, forbidden);
        end
    endtask

    initial begin
        logic [1:0]  exp_mode;
        logic [31:0] exp_word;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0;
        sweep_en = 1'b0; out_ready = 1'b1;

        // reset
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h00000000);
        chk("rst_out_oe", 32'(out_oe), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sweep_mode", 32'(sweep_mode), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        rst = 1'b0;

        // directed modes
        in_valid = 1'b1; in_data = 8'h85; in_mode = 2'd1;
        tick();
        chk("sign_85", out_data, 32'hFFFFFF85);
        chk("sign_valid", 32'(out_valid), 32'd1);
        chk("sign_mode", 32'(out_mode), 32'd1);
        in_mode = 2'd0;
        tick();
        chk("zero_85", out_data, 32'h00000085);
        in_data = 8'h05; in_mode = 2'd2;
        tick();
        chk("ones_05", out_data, 32'hFFFFFF05);
        in_data = 8'h5A; in_mode = 2'd3;
        tick();
        chk("hiz_oe", 32'(out_oe), 32'd0);
        chk("hiz_mode", 32'(out_mode), 32'd3);
        chk("hiz_valid", 32'(out_valid), 32'd1);
        chk_ne("hiz_not_driven", out_data, 32'h0000005A);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // backpressure
        in_valid = 1'b1; in_data = 8'h11; in_mode = 2'd0;
        tick();
        chk("bp_first", out_data, 32'h00000011);
        out_ready = 1'b0; in_data = 8'h22;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", out_data, 32'h00000011);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);
        tick();
        chk("bp_second", out_data, 32'h00000022);

        // sweep: 5 beats per mode, wrapping to ZERO on beat 21
        sweep_en = 1'b1; in_data = 8'h7F; in_mode = 2'd2;
        for (int i = 0; i < 21; i++) begin
            tick();
            exp_mode = 2'((i / 5) % 4);
            exp_word = (exp_mode == 2'd2) ? 32'hFFFFFF7F : 32'h0000007F;
            chk("sweep_mode_beat", 32'(out_mode), 32'(exp_mode));
            chk("sweep_oe_beat", 32'(out_oe), (exp_mode == 2'd3) ? 32'd0 : 32'd1);
            if (exp_mode != 2'd3) chk("sweep_data_beat", out_data, exp_word);
            chk("sweep_seq_mode", 32'(sweep_mode), 32'(((i + 1) / 5) % 4));
        end

        // reset in the middle of ONES with a word stalled downstream
        sweep_en = 1'b0; in_valid = 1'b0;
        tick();
        chk("sweep_off_clear", 32'(sweep_mode), 32'd0);
        sweep_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_ones_mode", 32'(sweep_mode), 32'd2);
        out_ready = 1'b0;
        tick();
        chk("mid_ones_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sweep", 32'(sweep_mode), 32'd0);
        chk("midrst_data", out_data, 32'h00000000);
        chk("midrst_oe", 32'(out_oe), 32'd1);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("restart_zero_beat", 32'(out_mode), 32'd0);
        end
        chk("restart_advance", 32'(sweep_mode), 32'd1);
        tick();
        chk("restart_sign_beat", 32'(out_mode), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
